instr_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the processor core. It steps each instruction through fetch, decode, execute, memory and writeback, and gates the decoder's control flags into single-cycle enables for the PC, instruction register, register file, data memory and display. It also implements the wait-for-input, display-hold and halt behaviours. It sits between `controlUnity` outputs and the datapath enables.

---
 rtl/instr_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_instr_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : instr_sequencer
//  Description : Multi-cycle instruction sequencer. Steps each instruction
//                through FETCH/DECODE/EXEC/MEM/WB, turns latched decoder
//                flags into single-cycle datapath enables, and implements
//                wait-for-input, display-hold and halt.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_sequencer #(
  parameter int SHOW_CYCLES = 50000000,
  parameter int CNT_W       = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cu_writeReg,
  input  logic       cu_Jump,
  input  logic       cu_inSignal,
  input  logic       cu_writeEnable,
  input  logic       cu_readEnable,
  input  logic       cu_Branch,
  input  logic       cu_hlt,
  input  logic       cu_reset,
  input  logic       cu_showDisplay,
  input  logic       aluZero,
  input  logic       inConfirm,
  input  logic       resume,
  output logic       irLoad,
  output logic       pcWrite,
  output logic [1:0] pcSrc,
  output logic       regWrite,
  output logic       memWrite,
  output logic       memRead,
  output logic       displayLoad,
  output logic       waitingInput,
  output logic       halted,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_WAITIN = 3'd5,
    S_SHOW   = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] C_SHOW_LOAD = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [1:0]       C_PC_INC    = 2'b00;
  localparam logic [1:0]       C_PC_BRANCH = 2'b01;
  localparam logic [1:0]       C_PC_JUMP   = 2'b10;
  localparam logic [1:0]       C_PC_ZERO   = 2'b11;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_inPrev;
  logic             r_resPrev;
  logic             r_writeReg;
  logic             r_jump;
  logic             r_inSignal;
  logic             r_writeEnable;
  logic             r_readEnable;
  logic             r_branch;
  logic             r_hlt;
  logic             r_reset;
  logic             r_showDisplay;
  logic             w_kill;
  logic             w_inRise;
  logic             w_resRise;

  // Reset/halt/jump own the instruction: every other flag is masked so
  // undefined decoder outputs for those opcodes cannot leak into the datapath.
  assign w_kill    = cu_reset | cu_hlt | cu_Jump;
  assign w_inRise  = inConfirm & ~r_inPrev;
  assign w_resRise = resume & ~r_resPrev;

  // State, latched flags, SHOW counter and switch edge history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_FETCH;
      r_cnt         <= '0;
      r_inPrev      <= 1'b1;
      r_resPrev     <= 1'b1;
      r_writeReg    <= 1'b0;
      r_jump        <= 1'b0;
      r_inSignal    <= 1'b0;
      r_writeEnable <= 1'b0;
      r_readEnable  <= 1'b0;
      r_branch      <= 1'b0;
      r_hlt         <= 1'b0;
      r_reset       <= 1'b0;
      r_showDisplay <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_inPrev  <= inConfirm;
      r_resPrev <= resume;
      if (r_state == S_DECODE) begin
        r_reset       <= cu_reset;
        r_hlt         <= cu_hlt;
        r_jump        <= cu_Jump;
        r_writeReg    <= cu_writeReg    & ~w_kill;
        r_inSignal    <= cu_inSignal    & ~w_kill;
        r_writeEnable <= cu_writeEnable & ~w_kill;
        r_readEnable  <= cu_readEnable  & ~w_kill;
        r_branch      <= cu_Branch      & ~w_kill;
        r_showDisplay <= cu_showDisplay & ~w_kill;
      end
      // WB reached from SHOW or HALT only advances the PC.
      if ((r_state == S_SHOW || r_state == S_HALT) && w_next == S_WB) begin
        r_writeReg <= 1'b0;
      end
      if (r_state == S_EXEC && w_next == S_SHOW) begin
        r_cnt <= C_SHOW_LOAD;
      end else if (r_state == S_SHOW && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // Next-state selection and Moore output decode, all forced low in reset.
  always_comb begin
    w_next       = r_state;
    irLoad       = 1'b0;
    pcWrite      = 1'b0;
    pcSrc        = C_PC_INC;
    regWrite     = 1'b0;
    memWrite     = 1'b0;
    memRead      = 1'b0;
    displayLoad  = 1'b0;
    waitingInput = 1'b0;
    halted       = 1'b0;
    state        = r_state;
    case (r_state)
      S_FETCH: begin
        irLoad = 1'b1;
        w_next = S_DECODE;
      end
      S_DECODE: begin
        w_next = S_EXEC;
      end
      S_EXEC: begin
        if (r_reset) begin
          pcWrite = 1'b1;
          pcSrc   = C_PC_ZERO;
          w_next  = S_FETCH;
        end else if (r_hlt) begin
          w_next = S_HALT;
        end else if (r_jump) begin
          pcWrite = 1'b1;
          pcSrc   = C_PC_JUMP;
          w_next  = S_FETCH;
        end else if (r_branch) begin
          pcWrite = 1'b1;
          pcSrc   = aluZero ? C_PC_BRANCH : C_PC_INC;
          w_next  = S_FETCH;
        end else if (r_inSignal) begin
          w_next = S_WAITIN;
        end else if (r_showDisplay) begin
          displayLoad = 1'b1;
          w_next      = S_SHOW;
        end else if (r_readEnable || r_writeEnable) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        memRead  = r_readEnable;
        memWrite = r_writeEnable;
        w_next   = S_WB;
      end
      S_WB: begin
        regWrite = r_writeReg;
        pcWrite  = 1'b1;
        pcSrc    = C_PC_INC;
        w_next   = S_FETCH;
      end
      S_WAITIN: begin
        waitingInput = 1'b1;
        if (w_inRise) w_next = S_WB;
      end
      S_SHOW: begin
        if (r_cnt == '0) w_next = S_WB;
      end
      S_HALT: begin
        halted = 1'b1;
        if (w_resRise) w_next = S_WB;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
    if (!rst_n) begin
      irLoad       = 1'b0;
      pcWrite      = 1'b0;
      pcSrc        = 2'b00;
      regWrite     = 1'b0;
      memWrite     = 1'b0;
      memRead      = 1'b0;
      displayLoad  = 1'b0;
      waitingInput = 1'b0;
      halted       = 1'b0;
      state        = 3'd0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_sequencer
//  Description : Self-checking bench for instr_sequencer. Each instruction is
//                expanded into its expected per-cycle output trace from the
//                timing rules; one process compares the DUT every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instr_sequencer;

  localparam int SC = 3;

  // flag vector bit positions: {show,rst,hlt,br,re,we,ins,jmp,wr}
  localparam logic [8:0] F_WR  = 9'h001;
  localparam logic [8:0] F_JMP = 9'h002;
  localparam logic [8:0] F_INS = 9'h004;
  localparam logic [8:0] F_WE  = 9'h008;
  localparam logic [8:0] F_RE  = 9'h010;
  localparam logic [8:0] F_BR  = 9'h020;
  localparam logic [8:0] F_HLT = 9'h040;
  localparam logic [8:0] F_RST = 9'h080;
  localparam logic [8:0] F_SHW = 9'h100;

  logic clk = 1'b0;
  logic rst_n;
  logic cu_writeReg, cu_Jump, cu_inSignal, cu_writeEnable, cu_readEnable;
  logic cu_Branch, cu_hlt, cu_reset, cu_showDisplay;
  logic aluZero, inConfirm, resume;
  logic irLoad, pcWrite, regWrite, memWrite, memRead, displayLoad;
  logic waitingInput, halted;
  logic [1:0] pcSrc;
  logic [2:0] state;

  always #5 clk = ~clk;

  instr_sequencer #(.SHOW_CYCLES(SC), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cu_writeReg(cu_writeReg), .cu_Jump(cu_Jump), .cu_inSignal(cu_inSignal),
    .cu_writeEnable(cu_writeEnable), .cu_readEnable(cu_readEnable),
    .cu_Branch(cu_Branch), .cu_hlt(cu_hlt), .cu_reset(cu_reset),
    .cu_showDisplay(cu_showDisplay), .aluZero(aluZero),
    .inConfirm(inConfirm), .resume(resume),
    .irLoad(irLoad), .pcWrite(pcWrite), .pcSrc(pcSrc), .regWrite(regWrite),
    .memWrite(memWrite), .memRead(memRead), .displayLoad(displayLoad),
    .waitingInput(waitingInput), .halted(halted), .state(state)
  );

  int checks   = 0;
  int failures = 0;
  logic [12:0] expq[$];
  logic [12:0] hist[$];
  bit prevIn, prevRes, g_icHigh;
  logic [12:0] got;

  assign got = {irLoad, pcWrite, pcSrc, regWrite, memWrite, memRead,
                displayLoad, waitingInput, halted, state};

  // Single compare process: every cycle with a pending expectation is checked.
  always @(negedge clk) begin
    logic [12:0] e;
    hist.push_back(got);
    if (expq.size() > 0) begin
      e = expq.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL trace cyc=%0d got=%b exp=%b", hist.size() - 1, got, e);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [12:0] mk(input bit ir, input bit pcw, input bit [1:0] pcs,
                                     input bit rw, input bit mw, input bit mr,
                                     input bit dl, input bit wi, input bit ha,
                                     input bit [2:0] st);
    return {ir, pcw, pcs, rw, mw, mr, dl, wi, ha, st};
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit ric();
    return g_icHigh ? 1'b1 : rb();
  endfunction

  // Level choice while waiting for an edge: forced hold, then random, then a
  // guaranteed toggle so every wait ends.
  function automatic bit pick(input int k, input bit prev, input int hold, input bit hl);
    if (k < hold) return hl;
    if (k >= hold + 20) return ~prev;
    return rb();
  endfunction

  task automatic cyc(input logic [12:0] e, input logic [8:0] fl, input bit az,
                     input bit ic, input bit rs);
    {cu_showDisplay, cu_reset, cu_hlt, cu_Branch, cu_readEnable,
     cu_writeEnable, cu_inSignal, cu_Jump, cu_writeReg} = fl;
    aluZero   = az;
    inConfirm = ic;
    resume    = rs;
    expq.push_back(e);
    @(posedge clk);
    #1;
    prevIn  = ic;
    prevRes = rs;
  endtask

  task automatic rcyc(input logic [12:0] e);
    cyc(e, 9'($urandom), rb(), ric(), rb());
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) rcyc(13'd0);
    prevIn  = 1'b1;
    prevRes = 1'b1;
    rst_n   = 1'b1;
  endtask

  task automatic pin(input string nm, input int idx, input logic [12:0] ex);
    checks++;
    if (hist[idx] !== ex) begin
      failures++;
      $display("FAIL pin_%s got=%b exp=%b", nm, hist[idx], ex);
    end
  endtask

  // Expand one instruction into its expected cycle trace and drive it.
  task automatic instr(input logic [8:0] f, input bit az, input int hold, input bit hl);
    bit lvl, rise;
    int k;
    rcyc(mk(1, 0, 2'd0, 0, 0, 0, 0, 0, 0, 3'd0));
    cyc(mk(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 3'd1), f, rb(), ric(), rb());
    if ((f & F_RST) != 0) begin
      cyc(mk(0, 1, 2'd3, 0, 0, 0, 0, 0, 0, 3'd2), 9'($urandom), az, ric(), rb());
    end else if ((f & F_HLT) != 0) begin
      cyc(mk(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 3'd2), 9'($urandom), az, ric(), rb());
      k = 0;
      forever begin
        lvl  = pick(k, prevRes, hold, hl);
        rise = lvl & ~prevRes;
        cyc(mk(0, 0, 2'd0, 0, 0, 0, 0, 0, 1, 3'd7), 9'($urandom), rb(), ric(), lvl);
        if (rise) break;
        k++;
      end
      rcyc(mk(0, 1, 2'd0, 0, 0, 0, 0, 0, 0, 3'd4));
    end else if ((f & F_JMP) != 0) begin
      cyc(mk(0, 1, 2'd2, 0, 0, 0, 0, 0, 0, 3'd2), 9'($urandom), az, ric(), rb());
    end else if ((f & F_BR) != 0) begin
      cyc(mk(0, 1, az ? 2'd1 : 2'd0, 0, 0, 0, 0, 0, 0, 3'd2), 9'($urandom), az, ric(), rb());
    end else if ((f & F_INS) != 0) begin
      cyc(mk(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 3'd2), 9'($urandom), az, ric(), rb());
      k = 0;
      forever begin
        lvl  = pick(k, prevIn, hold, hl);
        rise = lvl & ~prevIn;
        cyc(mk(0, 0, 2'd0, 0, 0, 0, 0, 1, 0, 3'd5), 9'($urandom), rb(), lvl, rb());
        if (rise) break;
        k++;
      end
      rcyc(mk(0, 1, 2'd0, f[0], 0, 0, 0, 0, 0, 3'd4));
    end else if ((f & F_SHW) != 0) begin
      cyc(mk(0, 0, 2'd0, 0, 0, 0, 1, 0, 0, 3'd2), 9'($urandom), az, ric(), rb());
      repeat (SC) rcyc(mk(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 3'd6));
      rcyc(mk(0, 1, 2'd0, 0, 0, 0, 0, 0, 0, 3'd4));
    end else if ((f & (F_RE | F_WE)) != 0) begin
      cyc(mk(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 3'd2), 9'($urandom), az, ric(), rb());
      rcyc(mk(0, 0, 2'd0, 0, f[3], f[4], 0, 0, 0, 3'd3));
      rcyc(mk(0, 1, 2'd0, f[0], 0, 0, 0, 0, 0, 3'd4));
    end else begin
      cyc(mk(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 3'd2), 9'($urandom), az, ric(), rb());
      rcyc(mk(0, 1, 2'd0, f[0], 0, 0, 0, 0, 0, 3'd4));
    end
  endtask

  initial begin
    int b;
    logic [8:0] f;
    rst_n = 1'b0;
    {cu_writeReg, cu_Jump, cu_inSignal, cu_writeEnable, cu_readEnable} = '0;
    {cu_Branch, cu_hlt, cu_reset, cu_showDisplay} = '0;
    aluZero = 1'b0; inConfirm = 1'b0; resume = 1'b0;
    prevIn = 1'b1; prevRes = 1'b1; g_icHigh = 1'b0;
    @(posedge clk); #1;
    do_reset(3);

    // ALU with writeReg
    b = hist.size();
    instr(F_WR, 1'b0, 0, 1'b0);
    pin("alu_c0", b,     13'b1_0_00_0_0_0_0_0_0_000);
    pin("alu_c3", b + 3, 13'b0_1_00_1_0_0_0_0_0_100);

    // store
    b = hist.size();
    instr(F_WE, 1'b0, 0, 1'b0);
    pin("alu_c4_fetch", b, 13'b1_0_00_0_0_0_0_0_0_000);
    pin("sw_c3", b + 3, 13'b0_0_00_0_1_0_0_0_0_011);
    pin("sw_c4", b + 4, 13'b0_1_00_0_0_0_0_0_0_100);

    // load
    instr(F_RE | F_WR, 1'b0, 0, 1'b0);

    // branches
    b = hist.size();
    instr(F_BR, 1'b1, 0, 1'b0);
    pin("br_taken", b + 2, 13'b0_1_01_0_0_0_0_0_0_010);
    instr(F_BR, 1'b0, 0, 1'b0);

    // jump with junk on every non-owning flag
    instr(((9'($urandom)) & ~(F_RST | F_HLT)) | F_JMP, rb(), 0, 1'b0);
    instr(9'h1FF & ~(F_RST | F_HLT), 1'b1, 0, 1'b0);

    // input held high through reset: no trigger until a real rise
    g_icHigh = 1'b1;
    do_reset(2);
    b = hist.size();
    instr(F_INS | F_WR, rb(), 10, 1'b1);
    g_icHigh = 1'b0;
    pin("in_wait_first", b + 3,  13'b0_0_00_0_0_0_0_1_0_101);
    pin("in_wait_last",  b + 12, 13'b0_0_00_0_0_0_0_1_0_101);

    // display hold
    b = hist.size();
    instr(F_SHW, 1'b0, 0, 1'b0);
    pin("out_c2", b + 2, 13'b0_0_00_0_0_0_1_0_0_010);
    pin("out_c3", b + 3, 13'b0_0_00_0_0_0_0_0_0_110);
    pin("out_c6", b + 6, 13'b0_1_00_0_0_0_0_0_0_100);

    // halt held for 100 cycles
    b = hist.size();
    instr(F_HLT | F_WR, 1'b0, 100, 1'b0);
    pin("hlt_first", b + 3,   13'b0_0_00_0_0_0_0_0_1_111);
    pin("hlt_100",   b + 102, 13'b0_0_00_0_0_0_0_0_1_111);

    // reset mid-SHOW
    rcyc(mk(1, 0, 2'd0, 0, 0, 0, 0, 0, 0, 3'd0));
    cyc(mk(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 3'd1), F_SHW | F_WR, 1'b0, rb(), rb());
    rcyc(mk(0, 0, 2'd0, 0, 0, 0, 1, 0, 0, 3'd2));
    rcyc(mk(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 3'd6));
    do_reset(2);
    b = hist.size();
    instr(F_WR, 1'b0, 0, 1'b0);
    pin("after_rst_fetch", b, 13'b1_0_00_0_0_0_0_0_0_000);

    // randomized instruction stream
    for (int i = 0; i < 150; i++) begin
      f = 9'($urandom);
      if ($urandom_range(0, 3) != 0) f = f & ~F_RST;
      if ($urandom_range(0, 3) != 0) f = f & ~F_HLT;
      if ($urandom_range(0, 2) != 0) f = f & ~F_JMP;
      if ($urandom_range(0, 2) != 0) f = f & ~F_BR;
      if ($urandom_range(0, 2) != 0) f = f & ~F_INS;
      if ($urandom_range(0, 2) != 0) f = f & ~F_SHW;
      if ($urandom_range(0, 29) == 0) do_reset(1 + $urandom_range(0, 1));
      instr(f, rb(), 0, 1'b0);
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
